// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle digit-serial adder with start/busy/done handshake
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]       a_sh, b_sh, acc, acc_nxt;
  logic [WIDTH+DIGIT-1:0] acc_cat;
  logic [CW-1:0]          cnt;
  logic                   carry;
  logic                   load, step, last;
  logic [DIGIT-1:0]       dig_sum;
  logic                   dig_cout, msb_cin;

  // Digit adder; the only carry path between digits is the carry register.
  always_comb begin
    {dig_cout, dig_sum} = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                          + (DIGIT+1)'(carry);
    // Carry into the digit's top bit recovered from that bit's sum and operands.
    msb_cin = dig_sum[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
    acc_cat = {dig_sum, acc};
    acc_nxt = acc_cat[WIDTH+DIGIT-1:DIGIT];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == LAST_CNT) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (step) begin
        a_sh  <= a_sh >> DIGIT;
        b_sh  <= b_sh >> DIGIT;
        acc   <= acc_nxt;
        carry <= dig_cout;
        cnt   <= cnt + CW'(1);
        if (last) begin
          sum  <= acc_nxt;
          cout <= dig_cout;
          ovf  <= msb_cin ^ dig_cout;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed-vector bench for serial_adder in three configurations
module tb_serial_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic       rst8_n, start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       rsto_n;
  logic       start4, cin4, busy4, done4, cout4, ovf4;
  logic [7:0] a4, b4, sum4;
  logic       start2, cin2, busy2, done2, cout2, ovf2;
  logic [1:0] a2, b2, sum2;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst_n(rsto_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));

  serial_adder #(.WIDTH(2), .DIGIT(1)) u_w2d1 (
    .clk(clk), .rst_n(rsto_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts an op at the next edge and returns at the negedge where done is high.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                     input logic [7:0] es, input logic ec, input logic eo, input string tag);
    int m, nbusy;
    a8 = ta; b8 = tbv; cin8 = tc; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    m = 0; nbusy = 0;
    while (!done8 && m < 20) begin
      if (busy8) nbusy++;
      @(negedge clk);
      m++;
    end
    chk({tag, " latency"}, m, 8);
    chk({tag, " busy_cycles"}, nbusy, 8);
    chk({tag, " busy_at_done"}, busy8, 1'b0);
    chk({tag, " sum"}, sum8, es);
    chk({tag, " cout"}, cout8, ec);
    chk({tag, " ovf"}, ovf8, eo);
  endtask

  task automatic op2(input logic [1:0] ta, input logic [1:0] tbv, input logic tc,
                     input logic [1:0] es, input logic ec, input logic eo, input string tag);
    int m;
    a2 = ta; b2 = tbv; cin2 = tc; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    m = 0;
    while (!done2 && m < 10) begin
      @(negedge clk);
      m++;
    end
    chk({tag, " latency"}, m, 2);
    chk({tag, " sum"}, sum2, es);
    chk({tag, " cout"}, cout2, ec);
    chk({tag, " ovf"}, ovf2, eo);
  endtask

  initial begin
    int m, ndone, s, sr, sa, sb;
    logic [4:0] v;
    logic [1:0] ta, tbv;
    logic tc;
    rst8_n = 1'b0; rsto_n = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
    repeat (2) @(negedge clk);
    chk("rst sum", sum8, 8'h00);
    chk("rst cout", cout8, 1'b0);
    chk("rst ovf", ovf8, 1'b0);
    chk("rst busy", busy8, 1'b0);
    chk("rst done", done8, 1'b0);
    rst8_n = 1'b1; rsto_n = 1'b1;
    @(negedge clk);

    op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "zero");
    @(negedge clk);
    chk("zero done_pulse_width", done8, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff_01");
    op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "7f_01");
    op8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, "80_80_c");
    @(negedge clk);

    // Restart attempt mid-run plus operand churn after capture.
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    m = 0;
    while (!done8 && m < 20) begin
      start8 = (m == 2);
      if (m == 2) begin a8 = 8'hFF; b8 = 8'hFF; end
      else begin a8 = 8'($urandom); b8 = 8'($urandom); end
      @(negedge clk);
      m++;
    end
    start8 = 1'b0;
    chk("ign_start latency", m, 8);
    chk("ign_start sum", sum8, 8'h46);
    chk("ign_start cout", cout8, 1'b0);
    op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "b2b");
    @(negedge clk);
    chk("b2b single_done", done8, 1'b0);

    op8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, "pre_rst");
    a8 = 8'h55; b8 = 8'h55; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst8_n = 1'b0;
    #1;
    chk("midrst sum", sum8, 8'h00);
    chk("midrst cout", cout8, 1'b0);
    chk("midrst ovf", ovf8, 1'b0);
    chk("midrst busy", busy8, 1'b0);
    chk("midrst done", done8, 1'b0);
    repeat (2) @(negedge clk);
    rst8_n = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("midrst no_done", ndone, 0);
    op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "post_rst");

    a4 = 8'hA5; b4 = 8'h5A; cin4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    m = 0;
    while (!done4 && m < 10) begin
      @(negedge clk);
      m++;
    end
    chk("d4 latency", m, 2);
    chk("d4 sum", sum4, 8'h00);
    chk("d4 cout", cout4, 1'b1);
    chk("d4 ovf", ovf4, 1'b0);
    chk("d4 busy_at_done", busy4, 1'b0);

    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      ta = v[4:3]; tbv = v[2:1]; tc = v[0];
      s = int'(ta) + int'(tbv) + int'(tc);
      sa = ta[1] ? int'(ta) - 4 : int'(ta);
      sb = tbv[1] ? int'(tbv) - 4 : int'(tbv);
      sr = sa + sb + int'(tc);
      op2(ta, tbv, tc, 2'(s), (s > 3), (sr > 1 || sr < -2), $sformatf("w2_%0d", i));
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
